// File: rtl/shared_divider_arb.sv
// shared_divider_arb: round-robin shared restoring divider for N_CH clients
// Ports: clock/reset (sync, active-high); req per-channel level request;
// dividend/divisor packed operands, channel i at [i*WIDTH +: WIDTH];
// grant one-hot owner; done one-cycle result pulse; quotient/remainder/div_zero
// held results; busy high while an operation is in flight.
module shared_divider_arb #(
  parameter int WIDTH = 12,
  parameter int N_CH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*WIDTH-1:0] dividend,
  input  logic [N_CH*WIDTH-1:0] divisor,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       done,
  output logic [WIDTH-1:0]      quotient,
  output logic [WIDTH-1:0]      remainder,
  output logic                  div_zero,
  output logic                  busy
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int NW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_last;
  logic [NW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [N_CH-1:0]  r_grant;
  logic [N_CH-1:0]  r_done;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
  logic             r_busy;
  logic             w_found;
  logic [CW-1:0]    w_sel;
  logic [CW-1:0]    w_j;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_q_n;
  // first requester searching upward from last-served + 1, wrapping
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last;
    w_j     = r_last;
    for (int i = 1; i <= N_CH; i++) begin
      w_j = CW'((int'(r_last) + i) % N_CH);
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        w_sel   = w_j;
      end
    end
  end
  assign w_a = dividend[int'(w_sel)*WIDTH +: WIDTH];
  assign w_b = divisor[int'(w_sel)*WIDTH +: WIDTH];
  // one restoring step: the shifted partial remainder needs one extra bit
  assign w_sh    = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = w_sh >= {1'b0, r_dvs};
  assign w_rem_n = w_ge ? WIDTH'(w_sh - {1'b0, r_dvs}) : w_sh[WIDTH-1:0];
  assign w_q_n   = {r_q[WIDTH-2:0], w_ge};
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= CW'(N_CH - 1);
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_dvs   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_quo   <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_found) begin
          r_last  <= w_sel;
          r_grant <= N_CH'(1) << w_sel;
          r_busy  <= 1'b1;
          r_q     <= w_a;
          r_dvs   <= w_b;
          r_rem   <= '0;
          r_cnt   <= NW'(WIDTH - 1);
          if (w_b == '0) begin
            r_state <= DONE;
            r_done  <= N_CH'(1) << w_sel;
            r_quo   <= '1;
            r_remo  <= w_a;
            r_dz    <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt - NW'(1);
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_done  <= r_grant;
            r_quo   <= w_q_n;
            r_remo  <= w_rem_n;
            r_dz    <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign grant     = r_grant;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_remo;
  assign div_zero  = r_dz;
  assign busy      = r_busy;
endmodule

// File: tb/tb_shared_divider_arb.sv
// tb_shared_divider_arb: scoreboard bench for the shared divider, WIDTH=12, N_CH=3
module tb_shared_divider_arb;
  localparam int W = 12;
  localparam int N = 3;
  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] dividend;
  logic [N*W-1:0] divisor;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           busy;
  typedef struct {int ch; int q; int r; int dz;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  shared_divider_arb #(.WIDTH(W), .N_CH(N)) dut (
    .clock(clock), .reset(reset), .req(req), .dividend(dividend), .divisor(divisor),
    .grant(grant), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // clients register done and drop their request in the same cycle
  task automatic tick();
    @(negedge clock);
    cyc++;
    req = req & ~done;
  endtask
  always @(negedge clock) begin
    if (!reset && done != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_onehot", int'(done), 1 << e.ch);
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_zero", int'(div_zero), e.dz);
      end
    end
  end
  task automatic set_op(input int ch, input int a, input int b);
    dividend[ch*W +: W] = W'(a);
    divisor[ch*W +: W]  = W'(b);
  endtask
  // mode 1: change operands after grant; mode 2: drop req after grant
  task automatic single(input int ch, input int a, input int b, input int eq,
                        input int er, input int edz, input int elat, input int mode);
    int lat;
    set_op(ch, a, b);
    sb.push_back('{ch, eq, er, edz});
    req[ch] = 1'b1;
    tick();
    lat = 1;
    chk("grant", int'(grant), 1 << ch);
    chk("busy", int'(busy), 1);
    if (mode == 1) begin
      set_op(ch, 50, 2);
      set_op((ch + 1) % N, 9, 0);
    end
    if (mode == 2) begin
      repeat (3) begin
        tick();
        lat++;
      end
      req[ch] = 1'b0;
    end
    while (done == '0 && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, elat);
    tick();
    chk("grant_idle", int'(grant), 0);
    chk("busy_idle", int'(busy), 0);
  endtask
  task automatic burst(input int want, input logic [N-1:0] r);
    int t[$];
    int lim;
    lim = 0;
    req = r;
    while (t.size() < want && lim < 100) begin
      tick();
      lim++;
      if (done != '0) t.push_back(cyc);
    end
    chk("burst_count", t.size(), want);
    if (t.size() == want)
      for (int i = 1; i < want; i++) chk("done_spacing", t[i] - t[i-1], 14);
    tick();
  endtask
  initial begin
    reset = 1'b1;
    req = '0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_div_zero", int'(div_zero), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    single(0, 100, 7, 14, 2, 0, 13, 0);
    single(0, 4095, 1, 4095, 0, 0, 13, 0);
    single(0, 5, 4095, 0, 5, 0, 13, 0);
    single(0, 4095, 4095, 1, 0, 0, 13, 0);
    single(1, 321, 0, 4095, 321, 1, 1, 0);
    single(0, 1000, 9, 111, 1, 0, 13, 1);
    single(2, 777, 10, 77, 7, 0, 13, 2);
    set_op(1, 200, 3);
    req[1] = 1'b1;
    tick();
    chk("mid_rst_grant", int'(grant), 2);
    repeat (5) tick();
    reset = 1'b1;
    req = '0;
    tick();
    chk("mid_rst_grant0", int'(grant), 0);
    chk("mid_rst_done0", int'(done), 0);
    chk("mid_rst_quotient0", int'(quotient), 0);
    chk("mid_rst_remainder0", int'(remainder), 0);
    chk("mid_rst_div_zero0", int'(div_zero), 0);
    chk("mid_rst_busy0", int'(busy), 0);
    reset = 1'b0;
    repeat (20) tick();
    set_op(0, 60, 7);
    set_op(1, 2000, 33);
    set_op(2, 4000, 100);
    sb.push_back('{0, 8, 4, 0});
    sb.push_back('{1, 60, 20, 0});
    sb.push_back('{2, 40, 0, 0});
    burst(3, 3'b111);
    set_op(0, 13, 5);
    set_op(2, 99, 9);
    sb.push_back('{0, 2, 3, 0});
    sb.push_back('{2, 11, 0, 0});
    burst(2, 3'b101);
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
